// File: rtl/m_serializer.sv
// ============================================================================
// Module   : m_serializer
// Purpose  : Parallel-in/serial-out stage with valid/ready load, framing, done.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module m_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             d_out,
    output logic             d_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_done;

    logic             w_last;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_strobe;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign w_last   = (r_bit_cnt == C_LAST);
    assign w_accept = load_valid & w_load_ready;
    assign w_strobe = (r_state == S_SHIFT) & shift_en;

    // The output end of shreg is fixed by LSB_FIRST; shifts always move toward it.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit = r_shreg[0];
        end else begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_shreg[WIDTH-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_strobe & w_last;
            if (w_accept) begin
                r_shreg   <= load_data;
                r_bit_cnt <= '0;
            end else if (w_strobe) begin
                if (w_last) begin
                    // Clearing on exit keeps d_out at 0 throughout IDLE.
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_shreg   <= w_shifted;
                    r_bit_cnt <= r_bit_cnt + C_ONE;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (load_valid) w_next_state = S_SHIFT;
            S_SHIFT: if (shift_en && w_last && !load_valid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_ready = 1'b0;
        d_valid      = 1'b0;
        busy         = 1'b0;
        frame_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_ready = ~reset;
            end
            S_SHIFT: begin
                w_load_ready = ~reset & w_last & shift_en;
                d_valid      = 1'b1;
                busy         = 1'b1;
                frame_start  = (r_bit_cnt == '0);
            end
            default: begin
                w_load_ready = 1'b0;
            end
        endcase
        load_ready = w_load_ready;
        d_out      = w_out_bit;
        done       = r_done;
    end

endmodule

`default_nettype wire
